// File: rtl/freq_sweep_controller.sv
// Stepped linear chirp generator for the sine generator's phase-increment word.
// Define FREQ_SWEEP_BIDIR_EN to add a down leg (stop_inc back to start_inc) after the up leg.
module freq_sweep_controller #(
    parameter int INC_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [INC_W-1:0]   start_inc,
    input  logic [INC_W-1:0]   stop_inc,
    input  logic [INC_W-1:0]   step_inc,
    input  logic [DWELL_W-1:0] dwell,
    output logic [INC_W-1:0]   freq_control,
    output logic               step_strobe,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    // Handshake: start is a 1-cycle request that is accepted only in IDLE with abort low;
    // abort is a level that cancels any active leg on the next edge. There is no ready signal.

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWEEP_UP   = 2'd1,
`ifdef FREQ_SWEEP_BIDIR_EN
        SWEEP_DOWN = 2'd2,
`endif
        FINISH     = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [INC_W-1:0]   fc_nxt;
    logic               strobe_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt;
    logic [INC_W-1:0]   cfg_stop, cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_degen;
    logic               accept;
    logic               dwell_end;
    logic [INC_W:0]     up_sum;
    logic [INC_W-1:0]   up_next;
`ifdef FREQ_SWEEP_BIDIR_EN
    logic [INC_W-1:0]   cfg_start;
    logic [INC_W:0]     dn_diff;
    logic [INC_W-1:0]   dn_next;
`endif

    assign busy      = (state == SWEEP_UP)
`ifdef FREQ_SWEEP_BIDIR_EN
                     || (state == SWEEP_DOWN)
`endif
                     ;
    assign done      = (state == FINISH);
    assign state_dbg = state;
    assign accept    = (state == IDLE) && start && !abort;
    assign dwell_end = (dwell_cnt == cfg_dwell);

    // One extra bit catches carry-out so the clamp never lets the word wrap.
    assign up_sum  = {1'b0, freq_control} + {1'b0, cfg_step};
    assign up_next = (up_sum[INC_W] || (up_sum[INC_W-1:0] >= cfg_stop)) ? cfg_stop : up_sum[INC_W-1:0];
`ifdef FREQ_SWEEP_BIDIR_EN
    assign dn_diff = {1'b0, freq_control} - {1'b0, cfg_step};
    assign dn_next = (dn_diff[INC_W] || (dn_diff[INC_W-1:0] <= cfg_start)) ? cfg_start : dn_diff[INC_W-1:0];
`endif

    always_comb begin
        state_nxt     = state;
        fc_nxt        = freq_control;
        strobe_nxt    = 1'b0;
        dwell_cnt_nxt = dwell_cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt     = SWEEP_UP;
                    fc_nxt        = start_inc;
                    strobe_nxt    = 1'b1;
                    dwell_cnt_nxt = DWELL_W'(1);
                end
            end
            SWEEP_UP: begin
                if (abort) begin
                    state_nxt     = IDLE;
                    fc_nxt        = '0;
                    dwell_cnt_nxt = '0;
                end else if (dwell_end) begin
                    if (cfg_degen) begin
                        state_nxt     = FINISH;
                        dwell_cnt_nxt = '0;
                    end else if (freq_control == cfg_stop) begin
`ifdef FREQ_SWEEP_BIDIR_EN
                        state_nxt     = SWEEP_DOWN;
                        fc_nxt        = dn_next;
                        strobe_nxt    = 1'b1;
                        dwell_cnt_nxt = DWELL_W'(1);
`else
                        state_nxt     = FINISH;
                        dwell_cnt_nxt = '0;
`endif
                    end else begin
                        fc_nxt        = up_next;
                        strobe_nxt    = 1'b1;
                        dwell_cnt_nxt = DWELL_W'(1);
                    end
                end else begin
                    dwell_cnt_nxt = dwell_cnt + DWELL_W'(1);
                end
            end
`ifdef FREQ_SWEEP_BIDIR_EN
            SWEEP_DOWN: begin
                if (abort) begin
                    state_nxt     = IDLE;
                    fc_nxt        = '0;
                    dwell_cnt_nxt = '0;
                end else if (dwell_end) begin
                    if (freq_control == cfg_start) begin
                        state_nxt     = FINISH;
                        dwell_cnt_nxt = '0;
                    end else begin
                        fc_nxt        = dn_next;
                        strobe_nxt    = 1'b1;
                        dwell_cnt_nxt = DWELL_W'(1);
                    end
                end else begin
                    dwell_cnt_nxt = dwell_cnt + DWELL_W'(1);
                end
            end
`endif
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            freq_control <= '0;
            step_strobe  <= 1'b0;
            dwell_cnt    <= '0;
            cfg_stop     <= '0;
            cfg_step     <= '0;
            cfg_dwell    <= '0;
            cfg_degen    <= 1'b0;
`ifdef FREQ_SWEEP_BIDIR_EN
            cfg_start    <= '0;
`endif
        end else begin
            state        <= state_nxt;
            freq_control <= fc_nxt;
            step_strobe  <= strobe_nxt;
            dwell_cnt    <= dwell_cnt_nxt;
            if (accept) begin
                cfg_stop  <= stop_inc;
                cfg_step  <= step_inc;
                cfg_dwell <= (dwell == '0) ? DWELL_W'(1) : dwell;
                cfg_degen <= (start_inc >= stop_inc) || (step_inc == '0);
`ifdef FREQ_SWEEP_BIDIR_EN
                cfg_start <= start_inc;
`endif
            end
        end
    end

endmodule

// File: tb/tb_freq_sweep_controller.sv
// Directed bench for freq_sweep_controller: traces outputs per cycle after each start
// and compares them with hand-listed value sequences expanded by dwell.
module tb_freq_sweep_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] start_inc = '0;
    logic [31:0] stop_inc = '0;
    logic [31:0] step_inc = '0;
    logic [15:0] dwell = '0;
    logic [31:0] freq_control;
    logic        step_strobe;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    logic [31:0] tr_fc [64];
    logic        tr_stb [64];
    logic        tr_busy [64];
    logic        tr_done [64];
    logic [34:0] exp_t [64];
    logic [31:0] exp_vals [$];

    freq_sweep_controller dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .start_inc(start_inc), .stop_inc(stop_inc), .step_inc(step_inc), .dwell(dwell),
        .freq_control(freq_control), .step_strobe(step_strobe), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start pulse; afterwards scramble the config inputs to prove they were latched.
    task automatic do_start(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                            input logic [15:0] d);
        start_inc = s; stop_inc = e; step_inc = st; dwell = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_inc = 32'h1234_5678; stop_inc = 32'h0000_0001; step_inc = 32'h0000_0003; dwell = 16'd9;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tr_fc[i] = freq_control; tr_stb[i] = step_strobe;
            tr_busy[i] = busy; tr_done[i] = done;
            tick();
        end
    endtask

    // Expand exp_vals (each held d cycles) into {fc, strobe, busy, done} per cycle.
    task automatic build_expect(input int d, input int n);
        int nv;
        nv = exp_vals.size();
        for (int i = 0; i < n; i++) begin
            if (i / d < nv)
                exp_t[i] = {exp_vals[i / d], (i % d) == 0, 1'b1, 1'b0};
            else
                exp_t[i] = {exp_vals[nv - 1], 1'b0, 1'b0, i == nv * d};
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({freq_control, step_strobe, busy, done, state_dbg} !== 37'd0) begin
            errors++; $display("FAIL reset_outputs got fc=%h stb=%b busy=%b done=%b st=%0d exp all 0",
                               freq_control, step_strobe, busy, done, state_dbg);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({freq_control, busy, state_dbg} !== 35'd0) begin
            errors++; $display("FAIL reset_release got fc=%h busy=%b st=%0d exp 0", freq_control, busy, state_dbg);
        end
    endtask

    task automatic test_basic_sweep();
        int n_stb;
        do_start(32'd100, 32'd130, 32'd10, 16'd3);
        capture(14);
        exp_vals = '{32'd100, 32'd110, 32'd120, 32'd130};
        build_expect(3, 14);
        n_stb = 0;
        for (int i = 0; i < 14; i++) begin
            n_stb += int'(tr_stb[i]);
            checks++;
            if ({tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i]} !== exp_t[i]) begin
                errors++; $display("FAIL basic_cyc%0d got fc=%0d stb/busy/done=%b%b%b exp fc=%0d %b",
                                   i, tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i], exp_t[i][34:3], exp_t[i][2:0]);
            end
        end
        checks++;
        if (n_stb != 4) begin
            errors++; $display("FAIL basic_strobes got %0d exp 4", n_stb);
        end
    endtask

    task automatic test_clamp();
        do_start(32'd100, 32'd125, 32'd10, 16'd2);
        capture(10);
        exp_vals = '{32'd100, 32'd110, 32'd120, 32'd125};
        build_expect(2, 10);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i]} !== exp_t[i]) begin
                errors++; $display("FAIL clamp_cyc%0d got fc=%0d stb/busy/done=%b%b%b exp fc=%0d %b",
                                   i, tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i], exp_t[i][34:3], exp_t[i][2:0]);
            end
        end
        // Abort in IDLE must leave the persisting tone alone.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        checks++;
        if ({freq_control, busy, done} !== {32'd125, 2'b00}) begin
            errors++; $display("FAIL idle_abort got fc=%0d busy=%b done=%b exp fc=125 0 0", freq_control, busy, done);
        end
    endtask

    task automatic test_carry_clamp();
        do_start(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1);
        capture(4);
        exp_vals = '{32'hFFFF_FFF0, 32'hFFFF_FFFF};
        build_expect(1, 4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i]} !== exp_t[i]) begin
                errors++; $display("FAIL carry_cyc%0d got fc=%h stb/busy/done=%b%b%b exp fc=%h %b",
                                   i, tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i], exp_t[i][34:3], exp_t[i][2:0]);
            end
        end
    endtask

    task automatic test_abort();
        do_start(32'd100, 32'd130, 32'd10, 16'd3);
        tick();
        // Second start mid-sweep must be ignored.
        start_inc = 32'd500; stop_inc = 32'd900; step_inc = 32'd50; dwell = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({freq_control, step_strobe, busy} !== {32'd100, 2'b01}) begin
            errors++; $display("FAIL ignore_start got fc=%0d stb=%b busy=%b exp fc=100 0 1", freq_control, step_strobe, busy);
        end
        tick();
        checks++;
        if ({freq_control, step_strobe} !== {32'd110, 1'b1}) begin
            errors++; $display("FAIL pre_abort got fc=%0d stb=%b exp fc=110 1", freq_control, step_strobe);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        capture(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i]} !== 35'd0) begin
                errors++; $display("FAIL abort_cyc%0d got fc=%0d stb/busy/done=%b%b%b exp fc=0 000",
                                   i, tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i]);
            end
        end
        // start together with abort: abort wins.
        start_inc = 32'd77; stop_inc = 32'd99; step_inc = 32'd1; dwell = 16'd1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        checks++;
        if ({freq_control, busy, state_dbg} !== 35'd0) begin
            errors++; $display("FAIL start_abort got fc=%0d busy=%b st=%0d exp 0 0 0", freq_control, busy, state_dbg);
        end
    endtask

    task automatic test_async_reset();
        do_start(32'd100, 32'd130, 32'd10, 16'd3);
        capture(6);
        checks++;
        if (freq_control !== 32'd120) begin
            errors++; $display("FAIL prereset_fc got %0d exp 120", freq_control);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({freq_control, step_strobe, busy, done, state_dbg} !== 37'd0) begin
            errors++; $display("FAIL async_reset got fc=%0d stb=%b busy=%b done=%b st=%0d exp all 0",
                               freq_control, step_strobe, busy, done, state_dbg);
        end
        tick();
        reset = 1'b1;
        capture(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i]} !== 35'd0) begin
                errors++; $display("FAIL post_reset_cyc%0d got fc=%0d stb/busy/done=%b%b%b exp 0",
                                   i, tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i]);
            end
        end
    endtask

    task automatic test_degenerate_and_bidir();
        int n;
        do_start(32'd10, 32'd30, 32'd10, 16'd1);
`ifdef FREQ_SWEEP_BIDIR_EN
        exp_vals = '{32'd10, 32'd20, 32'd30, 32'd20, 32'd10};
        n = 7;
`else
        exp_vals = '{32'd10, 32'd20, 32'd30};
        n = 5;
`endif
        capture(n);
        build_expect(1, n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if ({tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i]} !== exp_t[i]) begin
                errors++; $display("FAIL sweep10_cyc%0d got fc=%0d stb/busy/done=%b%b%b exp fc=%0d %b",
                                   i, tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i], exp_t[i][34:3], exp_t[i][2:0]);
            end
        end
        do_start(32'd50, 32'd40, 32'd10, 16'd2);
        capture(4);
        exp_vals = '{32'd50};
        build_expect(2, 4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i]} !== exp_t[i]) begin
                errors++; $display("FAIL start_ge_stop_cyc%0d got fc=%0d stb/busy/done=%b%b%b exp fc=%0d %b",
                                   i, tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i], exp_t[i][34:3], exp_t[i][2:0]);
            end
        end
        // Zero step and zero dwell: single value held one cycle.
        do_start(32'd7, 32'd100, 32'd0, 16'd0);
        capture(3);
        exp_vals = '{32'd7};
        build_expect(1, 3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i]} !== exp_t[i]) begin
                errors++; $display("FAIL zero_step_cyc%0d got fc=%0d stb/busy/done=%b%b%b exp fc=%0d %b",
                                   i, tr_fc[i], tr_stb[i], tr_busy[i], tr_done[i], exp_t[i][34:3], exp_t[i][2:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_clamp();
        test_carry_clamp();
        test_abort();
        test_async_reset();
        test_degenerate_and_bidir();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
